// File: rtl/psg_bus_arbiter.sv
// psg_bus_arbiter: round-robin two-port arbiter driving PSG BDIR/BC strobe sequences.
// Optional PSG_ADDR_CACHE_EN skips the address phase when the PSG already holds the register number.
module psg_bus_arbiter #(
   parameter int PULSE = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic       WE0,
   input  logic       WE1,
   input  logic [3:0] ADDR0,
   input  logic [3:0] ADDR1,
   input  logic [7:0] WDATA0,
   input  logic [7:0] WDATA1,
   output logic       ACK0,
   output logic       ACK1,
   output logic [7:0] RDATA,
   output logic       PSG_BDIR,
   output logic       PSG_BC,
   output logic [7:0] PSG_DI,
   input  logic [7:0] PSG_DO
);
   typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, READ} state_t;
   localparam logic [3:0] P_LAST = 4'(PULSE - 1);
   state_t state, nxt;
   logic [3:0] cnt, nxt_cnt, addr, cur_addr, sel_addr;
   logic [7:0] wdata, cur_wdata;
   logic last, port, we, sel, sel_we, gnt, done, hit, ack_n, cur_port;
`ifdef PSG_ADDR_CACHE_EN
   logic       cache_valid;
   logic [3:0] cache_addr;
`endif
   always_comb begin
      gnt = REQ0 | REQ1;
      sel = (REQ0 & REQ1) ? ~last : REQ1;
      sel_we = sel ? WE1 : WE0;
      sel_addr = sel ? ADDR1 : ADDR0;
      // In IDLE the outputs for the first phase come straight from the winning port
      cur_port = (state == IDLE) ? sel : port;
      cur_addr = (state == IDLE) ? sel_addr : addr;
      cur_wdata = (state == IDLE) ? (sel ? WDATA1 : WDATA0) : wdata;
      done = cnt == P_LAST;
`ifdef PSG_ADDR_CACHE_EN
      hit = cache_valid && cache_addr == sel_addr;
`else
      hit = 1'b0;
`endif
      nxt = state;
      case (state)
         IDLE:    nxt = !gnt ? IDLE : !hit ? ADDR_HI : sel_we ? DATA_HI : READ;
         ADDR_HI: if (done) nxt = ADDR_LO;
         ADDR_LO: if (done) nxt = we ? DATA_HI : READ;
         DATA_HI: if (done) nxt = DATA_LO;
         DATA_LO: if (done) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      nxt_cnt = (nxt != state || state == IDLE) ? 4'd0 : cnt + 4'd1;
      ack_n = nxt == READ || (nxt == DATA_LO && nxt_cnt == P_LAST);
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         cnt <= '0;
         last <= 1'b1;
         port <= 1'b0;
         we <= 1'b0;
         addr <= '0;
         wdata <= '0;
         ACK0 <= 1'b0;
         ACK1 <= 1'b0;
         RDATA <= '0;
         PSG_BDIR <= 1'b0;
         PSG_BC <= 1'b0;
         PSG_DI <= '0;
`ifdef PSG_ADDR_CACHE_EN
         cache_valid <= 1'b0;
         cache_addr <= '0;
`endif
      end else begin
         state <= nxt;
         cnt <= nxt_cnt;
         if (state == IDLE && gnt) begin
            port <= sel;
            last <= sel;
            we <= sel_we;
            addr <= sel_addr;
            wdata <= cur_wdata;
         end
         PSG_BDIR <= nxt == ADDR_HI || nxt == DATA_HI;
         PSG_BC <= nxt == ADDR_HI;
         PSG_DI <= (nxt == ADDR_HI || nxt == ADDR_LO) ? {4'h0, cur_addr} :
                   (nxt == DATA_HI || nxt == DATA_LO) ? cur_wdata : 8'h00;
         ACK0 <= ack_n & ~cur_port;
         ACK1 <= ack_n & cur_port;
         if (nxt == READ) RDATA <= PSG_DO;
`ifdef PSG_ADDR_CACHE_EN
         if (state == ADDR_HI) begin
            cache_valid <= 1'b1;
            cache_addr <= addr;
         end
`endif
      end
   end
endmodule

// File: tb/tb_psg_bus_arbiter.sv
// tb_psg_bus_arbiter: scoreboard bench with a PSG register-file model on a PULSE=1 and a PULSE=3 arbiter.
module tb_psg_bus_arbiter;
   logic clk = 0, rst = 1;
   int cyc = 0, n_checks = 0, n_fail = 0;
   logic a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0, a_ack0, a_ack1, a_bdir, a_bc;
   logic [3:0] a_addr0 = 0, a_addr1 = 0;
   logic [7:0] a_wdata0 = 0, a_wdata1 = 0, a_rdata, a_di, a_do;
   logic b_req1 = 0, b_ack0, b_ack1, b_bdir, b_bc;
   logic [3:0] b_addr1 = 0;
   logic [7:0] b_rdata, b_di, b_do;
   logic [7:0] pa[16], pb[16];
   logic [3:0] aa, ab;
   logic prev_bdir = 0;
   typedef struct {bit port; bit rd; logic [7:0] data; int cyc;} exp_t;
   exp_t qa[$], qb[$];
   exp_t ea, eb;
`ifdef PSG_ADDR_CACHE_EN
   localparam int CACHED = 1;
`else
   localparam int CACHED = 0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   psg_bus_arbiter #(.PULSE(1)) dut_a (
      .CLK(clk), .RESET(rst), .REQ0(a_req0), .REQ1(a_req1), .WE0(a_we0), .WE1(a_we1),
      .ADDR0(a_addr0), .ADDR1(a_addr1), .WDATA0(a_wdata0), .WDATA1(a_wdata1),
      .ACK0(a_ack0), .ACK1(a_ack1), .RDATA(a_rdata), .PSG_BDIR(a_bdir), .PSG_BC(a_bc),
      .PSG_DI(a_di), .PSG_DO(a_do));
   psg_bus_arbiter #(.PULSE(3)) dut_b (
      .CLK(clk), .RESET(rst), .REQ0(1'b0), .REQ1(b_req1), .WE0(1'b0), .WE1(1'b0),
      .ADDR0(4'h0), .ADDR1(b_addr1), .WDATA0(8'h00), .WDATA1(8'h00),
      .ACK0(b_ack0), .ACK1(b_ack1), .RDATA(b_rdata), .PSG_BDIR(b_bdir), .PSG_BC(b_bc),
      .PSG_DI(b_di), .PSG_DO(b_do));

   // PSG model: latches on BDIR high; register 7 (mixer) resets to 0xFF
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            pa[i] <= (i == 7) ? 8'hFF : 8'h00;
            pb[i] <= (i == 7) ? 8'hFF : 8'h00;
         end
         aa <= 0;
         ab <= 0;
      end else begin
         if (a_bdir) begin
            if (a_bc) aa <= a_di[3:0];
            else pa[aa] <= a_di;
         end
         if (b_bdir) begin
            if (b_bc) ab <= b_di[3:0];
            else pb[ab] <= b_di;
         end
      end
   end
   assign a_do = pa[aa];
   assign b_do = pb[ab];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   always @(negedge clk) if (!rst && (a_ack0 || a_ack1)) begin
      check("ack_overlap", 32'(a_ack0 & a_ack1), 0);
      if (qa.size() == 0) check("unexpected_ack", 1, 0);
      else begin
         ea = qa.pop_front();
         check("ack_port", 32'(a_ack1), 32'(ea.port));
         check("ack_cycle", 32'(cyc), 32'(ea.cyc));
         if (ea.rd) check("rdata", 32'(a_rdata), 32'(ea.data));
      end
   end

   always @(negedge clk) if (!rst && (b_ack0 || b_ack1)) begin
      if (qb.size() == 0) check("b_unexpected_ack", 1, 0);
      else begin
         eb = qb.pop_front();
         check("b_ack_port", 32'(b_ack1), 32'(eb.port));
         check("b_ack_cycle", 32'(cyc), 32'(eb.cyc));
         if (eb.rd) check("b_rdata", 32'(b_rdata), 32'(eb.data));
      end
   end

   always @(negedge clk) begin
      if (a_bdir) check("bdir_gap", 32'(prev_bdir), 0);
      prev_bdir = a_bdir;
   end

   task automatic do_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic rq(input bit p, input bit we, input logic [3:0] ad, input logic [7:0] d);
      bit got = 0;
      if (p) begin a_we1 = we; a_addr1 = ad; a_wdata1 = d; a_req1 = 1; end
      else begin a_we0 = we; a_addr0 = ad; a_wdata0 = d; a_req0 = 1; end
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = p ? a_ack1 : a_ack0;
      end
      check("ack_seen", 32'(got), 1);
      @(posedge clk);
      #1;
      if (p) a_req1 = 0;
      else a_req0 = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, n;
      do_reset;
      @(negedge clk);
      check("rst_ack0", 32'(a_ack0), 0);
      check("rst_ack1", 32'(a_ack1), 0);
      check("rst_rdata", 32'(a_rdata), 0);
      check("rst_bdir", 32'(a_bdir), 0);
      check("rst_bc", 32'(a_bc), 0);
      check("rst_di", 32'(a_di), 0);
      // PULSE=3: port 1 reads reg 7
      @(posedge clk); #1; t = cyc;
      qb.push_back(exp_t'{1'b1, 1'b1, 8'hFF, t + 7});
      b_addr1 = 7;
      b_req1 = 1;
      n = 0;
      while (n < 50 && !b_ack1) begin @(negedge clk); n++; end
      check("b_ack_seen", 32'(b_ack1), 1);
      @(posedge clk); #1 b_req1 = 0;
      do_reset;
      @(negedge clk);
      check("b_rdata_reset", 32'(b_rdata), 0);
      // Port 0 writes reg 8 = 0x1F with pin-level waveform check
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b0, 1'b0, 8'h00, t + 4});
      fork
         rq(0, 1, 8, 8'h1F);
         begin
            @(negedge clk);
            for (int k = 1; k <= 4; k++) begin
               @(negedge clk);
               check("w_bdir", 32'(a_bdir), 32'(k == 1 || k == 3));
               check("w_bc", 32'(a_bc), 32'(k == 1));
               if (k == 1) check("w_di_addr", 32'(a_di), 32'h08);
               if (k == 3) check("w_di_data", 32'(a_di), 32'h1F);
            end
         end
      join
      check("reg8", 32'(pa[8]), 32'h1F);
      // Round robin: first tie goes to port 0, tie after a port-0 grant goes to port 1
      do_reset;
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b0, 1'b0, 8'h00, t + 4});
      qa.push_back(exp_t'{1'b1, 1'b0, 8'h00, t + 9});
      fork
         rq(0, 1, 1, 8'h5A);
         rq(1, 1, 2, 8'hC6);
      join
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b0, 1'b0, 8'h00, t + 4});
      rq(0, 1, 9, 8'h99);
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b1, 1'b1, 8'hC6, t + 3});
      qa.push_back(exp_t'{1'b0, 1'b1, 8'h5A, t + 7});
      fork
         rq(1, 0, 2, 8'h00);
         rq(0, 0, 1, 8'h00);
      join
      check("reg9", 32'(pa[9]), 32'h99);
      // Two writes to reg 13: the second may skip the address phase
      do_reset;
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b0, 1'b0, 8'h00, t + 4});
      rq(0, 1, 13, 8'h11);
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b0, 1'b0, 8'h00, t + (CACHED != 0 ? 2 : 4)});
      fork
         rq(0, 1, 13, 8'h22);
         begin
            n = 0;
            repeat (6) begin @(negedge clk); n += 32'(a_bc); end
            check("bc_strobes", 32'(n), CACHED != 0 ? 0 : 1);
         end
      join
      check("reg13", 32'(pa[13]), 32'h22);
      // Reset during DATA_HI: aborted, then re-served from IDLE with full address phase
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b0, 1'b0, 8'h00, t + 8});
      fork
         rq(0, 1, 3, 8'hA5);
         begin
            repeat (3) @(posedge clk);
            #1 rst = 1;
            @(negedge clk);
            check("pre_rst_bdir", 32'(a_bdir), 1);
            @(posedge clk);
            #1 rst = 0;
            @(negedge clk);
            check("post_rst_bdir", 32'(a_bdir), 0);
            check("post_rst_bc", 32'(a_bc), 0);
            check("post_rst_ack0", 32'(a_ack0), 0);
         end
      join
      check("reg3", 32'(pa[3]), 32'hA5);
      // Fields changed mid-sequence must be ignored
      @(posedge clk); #1; t = cyc;
      qa.push_back(exp_t'{1'b0, 1'b0, 8'h00, t + 4});
      fork
         rq(0, 1, 5, 8'h3C);
         begin
            repeat (2) @(posedge clk);
            #1 a_wdata0 = 8'hC3;
            a_addr0 = 6;
         end
      join
      check("reg5", 32'(pa[5]), 32'h3C);
      check("reg6", 32'(pa[6]), 32'h00);
      n = 0;
      while (n < 50 && (qa.size() + qb.size()) != 0) begin @(posedge clk); n++; end
      check("scoreboard_empty", 32'(qa.size() + qb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/psg_bus_arbiter.md
# psg_bus_arbiter

- Two-port arbiter and bus sequencer in front of the PSG (AY/YM2149-style) register interface.
- Each requester issues one atomic register access: 4-bit register number plus write data, or a read.
- The block turns each access into correctly spaced BDIR/BC strobe cycles: an address latch, then a data write or a read-back sample.
- Sits between the CPU I/O decode (port 0) and the music-player/DMA engine (port 1) on one side, and the PSG bus pins on the other. The PSG shares CLK and RESET.

## Interface

Parameters:
- PULSE, 1: clocks per strobe phase (BDIR high and BDIR low); legal range 1..15.

Ports (reset RESET, synchronous, active-high; clock CLK):
- CLK  in  1  system clock, same clock as the PSG
- RESET  in  1  synchronous, active-high
- REQ0, REQ1  in  1  request from port 0/1; held with fields stable until ACKn
- WE0, WE1  in  1  1 = write, 0 = read
- ADDR0, ADDR1  in  4  PSG register number
- WDATA0, WDATA1  in  8  write data
- ACK0, ACK1  out  1  one-cycle completion pulse
- RDATA  out  8  read result; valid while ACKn is high for a read
- PSG_BDIR  out  1  to PSG BDIR
- PSG_BC  out  1  to PSG BC
- PSG_DI  out  8  to PSG DI
- PSG_DO  in  8  from PSG DO; combinational on the PSG side

## Operation

States and phases:
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, READ.
- Every HI/LO phase lasts exactly PULSE cycles, timed by a 4-bit phase counter.

Arbitration:
- Arbitration happens only in IDLE.
- If only one REQ is high, that port is granted.
- If both are high, the port not granted last wins (round-robin). The last-grant pointer resets to 1, so port 0 wins the first tie.
- The granted port's WE/ADDR/WDATA are latched on the grant edge. Later changes on the inputs are ignored.

Phase outputs:
- ADDR_HI: BDIR=1, BC=1, DI=latched addr.
- ADDR_LO: BDIR=0, BC=0, DI=latched addr.
- DATA_HI: BDIR=1, BC=0, DI=latched data.
- DATA_LO: BDIR=0, BC=0, DI=latched data.
- READ: BDIR=0, BC=0.

Sequences:
- Write: IDLE → ADDR_HI → ADDR_LO → DATA_HI → DATA_LO → IDLE.
- Read: IDLE → ADDR_HI → ADDR_LO → READ → IDLE.
- On a read, RDATA is sampled from PSG_DO at the final edge of ADDR_LO.

Completion:
- ACKn is registered and is high for exactly one cycle per granted request.
- ACK1 and ACK0 are never high in the same cycle.
- RDATA holds its value until the next read completes.

Reset:
- All outputs go to 0: BDIR, BC, DI, ACK0, ACK1, RDATA.
- State returns to IDLE, the pointer to 1 and the address cache to invalid.
- This applies in any state, mid-sequence included. An interrupted request is not acknowledged; the requester keeps REQ high and is re-served.

## Timing

Grant cycle T is the IDLE cycle in which REQ is sampled high.

Uncached write:
- ADDR_HI: T+1..T+P.
- ADDR_LO: T+P+1..T+2P.
- DATA_HI: T+2P+1..T+3P.
- DATA_LO: T+3P+1..T+4P.
- ACK is high during T+4P; IDLE at T+4P+1.

Uncached read:
- Address phases as for a write.
- ACK and RDATA are valid during T+2P+1 (READ); IDLE at T+2P+2.

Strobe spacing:
- BDIR is never high in two consecutive phases; a low phase of at least P cycles always separates strobes.
- The PSG latches on its own registered BDIR rising edge, so its address is updated by T+2 and PSG_DO is stable by the sampling edge.

Back-to-back requests:
- A requester sees ACK in cycle A and updates REQ/fields at the edge ending A.
- The block is in IDLE at A+1, so it never double-grants a request.
- Another request can be granted in cycle A+1.

## Configuration

- PSG_ADDR_CACHE_EN defined: the block keeps cache_valid plus the last register number latched into the PSG.
  - A request whose ADDR equals the cached value skips ADDR_HI/ADDR_LO.
  - Cached write: DATA_HI T+1..T+P, DATA_LO T+P+1..T+2P, ACK during T+2P.
  - Cached read: IDLE → READ directly, sampling PSG_DO at the grant edge; ACK during T+1.
  - Each ADDR_HI phase sets cache_valid and loads the cache.
  - RESET clears the cache; after reset the PSG address register is 0, but the cache stays invalid until the first address phase.
- Not defined: every access runs the full address phase; no cache logic is present.

## Test plan

- Reset, PULSE=1, port 0 writes reg 8 = 0x1F → BDIR high T+1 (BC=1, DI=0x08), high T+3 (BC=0, DI=0x1F), ACK0 at T+4; PSG reg 8 reads back 0x1F.
- REQ0 and REQ1 rise together, repeatedly → grants alternate 0,1,0,1; ACKs never overlap; BDIR always low ≥P cycles between highs.
- PULSE=3, port 1 reads reg 7 after reset → ACK1 at T+7, RDATA=0xFF.
- With PSG_ADDR_CACHE_EN: two writes to reg 13 → first ACK at T+4; second has no BC=1 strobe and ACK at T+2 (P=1). Without the macro, both take 4 cycles.
- RESET asserted during DATA_HI → next cycle BDIR=0, no ACK. After release, the still-held request completes with the full address phase and the written value lands.
- Port 0 changes WDATA mid-sequence → the value originally latched at grant is written.
